key_conditioner: RTL and testbench

KEY_CONDITIONER -- requirements
Module: key_conditioner

---
 rtl/key_conditioner_if.sv | 31 +++
 rtl/key_conditioner.sv | 130 +++++++++++++
 tb/tb_key_conditioner.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_conditioner_if.sv
// key_conditioner_if: signal bundle between the pushbutton/game-step side and
// the key conditioner.
//   KEY1     raw right-turn pushbutton, asynchronous, active-low
//   KEY3     raw left-turn pushbutton, asynchronous, active-low
//   game_tik one-cycle strobe marking a snake move step
//   right_P  pending right-turn command, active-high
//   left_P   pending left-turn command, active-high
// master drives keys and game_tik and reads the commands; slave is the conditioner.
interface key_conditioner_if;
    logic KEY1;
    logic KEY3;
    logic game_tik;
    logic right_P;
    logic left_P;

    modport master (
        output KEY1,
        output KEY3,
        output game_tik,
        input  right_P,
        input  left_P
    );

    modport slave (
        input  KEY1,
        input  KEY3,
        input  game_tik,
        output right_P,
        output left_P
    );
endinterface

// File: rtl/key_conditioner.sv
// key_conditioner: synchronizes and debounces two active-low pushbuttons and
// turns each accepted press into a pending turn command that the game
// consumes on its move strobe.
//   clock_25  sole clock (25 MHz pixel clock)
//   reset     asynchronous, active-low reset
//   bus       key_conditioner_if.slave: KEY1/KEY3 raw keys, game_tik strobe,
//             right_P/left_P pending command outputs
// Parameters: DEBOUNCE_CYCLES stable cycles to accept a level change,
//             CNT_BIT counter width (2**CNT_BIT > DEBOUNCE_CYCLES).
module key_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_BIT         = 18
) (
    input logic              clock_25,
    input logic              reset,
    key_conditioner_if.slave bus
);

    typedef enum logic [1:0] {
        RELEASED      = 2'd0,
        PRESS_CHECK   = 2'd1,
        PRESSED       = 2'd2,
        RELEASE_CHECK = 2'd3
    } db_state_t;

    typedef enum logic [1:0] {
        NONE  = 2'b00,
        LEFT  = 2'b01,
        RIGHT = 2'b10
    } cmd_t;

    localparam logic [CNT_BIT-1:0] LAST_COUNT = CNT_BIT'(DEBOUNCE_CYCLES - 1);

    // Index 0 is the right-turn key (KEY1), index 1 the left-turn key (KEY3).
    logic [1:0]         raw;
    logic [1:0]         sync_a;
    logic [1:0]         sync_b;
    logic [1:0]         press;
    db_state_t          state [2];
    logic [CNT_BIT-1:0] count [2];
    cmd_t               pending;

    assign raw = {bus.KEY3, bus.KEY1};

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            sync_a <= '1;
            sync_b <= '1;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    // Both check states count the level samples after entry; the transition
    // is taken on the sample where the count already sits at LAST_COUNT.
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            for (int unsigned k = 0; k < 2; k++) begin
                state[k] <= RELEASED;
                count[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < 2; k++) begin
                unique case (state[k])
                    RELEASED: begin
                        if (!sync_b[k]) begin
                            state[k] <= PRESS_CHECK;
                            count[k] <= '0;
                        end
                    end
                    PRESS_CHECK: begin
                        if (sync_b[k]) begin
                            state[k] <= RELEASED;
                            count[k] <= '0;
                        end else if (count[k] == LAST_COUNT) begin
                            state[k] <= PRESSED;
                            count[k] <= '0;
                        end else begin
                            count[k] <= count[k] + CNT_BIT'(1);
                        end
                    end
                    PRESSED: begin
                        if (sync_b[k]) begin
                            state[k] <= RELEASE_CHECK;
                            count[k] <= '0;
                        end
                    end
                    RELEASE_CHECK: begin
                        if (!sync_b[k]) begin
                            state[k] <= PRESSED;
                            count[k] <= '0;
                        end else if (count[k] == LAST_COUNT) begin
                            state[k] <= RELEASED;
                            count[k] <= '0;
                        end else begin
                            count[k] <= count[k] + CNT_BIT'(1);
                        end
                    end
                endcase
            end
        end
    end

    // Press event is decoded from the PRESS_CHECK -> PRESSED transition so the
    // pending register loads on the same edge the FSM enters PRESSED.
    always_comb begin
        press = '0;
        for (int unsigned k = 0; k < 2; k++) begin
            press[k] = (state[k] == PRESS_CHECK) && !sync_b[k] && (count[k] == LAST_COUNT);
        end
    end

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            pending <= NONE;
        end else begin
            case (press)
                2'b01:   pending <= RIGHT;
                2'b10:   pending <= LEFT;
                2'b00:   if (bus.game_tik) pending <= NONE;
                default: pending <= pending;
            endcase
        end
    end

    assign bus.right_P = (pending == RIGHT);
    assign bus.left_P  = (pending == LEFT);

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed scenarios plus randomized key/tik/reset traffic
// for key_conditioner with DEBOUNCE_CYCLES = 4.
module tb_key_conditioner;

    localparam int unsigned D   = 4;
    localparam int          LAT = 2 + D + 1;

    typedef enum {P_NONE, P_LEFT, P_RIGHT} cmd_t;

    logic clock_25 = 1'b0;
    logic reset    = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    key_conditioner_if bus ();

    key_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .CNT_BIT        (3)
    ) dut (
        .clock_25(clock_25),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clock_25 = ~clock_25;

    // Reference model: a key level is accepted once the synchronized level has
    // held a new value for D+1 consecutive samples; acceptance of 0 is a press.
    logic m_s1   [2];
    logic m_s2   [2];
    logic m_acc  [2];
    logic m_last [2];
    int   m_run  [2];
    cmd_t m_cmd;

    always @(posedge clock_25 or negedge reset) begin : model
        logic lvl;
        logic acc_n;
        logic last_n;
        int   run_n;
        logic ev [2];
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                m_s1[k]   <= 1'b1;
                m_s2[k]   <= 1'b1;
                m_acc[k]  <= 1'b1;
                m_last[k] <= 1'b1;
                m_run[k]  <= 0;
            end
            m_cmd <= P_NONE;
        end else begin
            for (int k = 0; k < 2; k++) begin
                lvl    = m_s2[k];
                acc_n  = m_acc[k];
                last_n = m_last[k];
                run_n  = m_run[k];
                if (lvl == last_n) run_n = run_n + 1;
                else begin
                    last_n = lvl;
                    run_n  = 1;
                end
                ev[k] = 1'b0;
                if (lvl != acc_n && run_n == D + 1) begin
                    acc_n = lvl;
                    ev[k] = !lvl;
                end
                m_acc[k]  <= acc_n;
                m_last[k] <= last_n;
                m_run[k]  <= run_n;
                m_s2[k]   <= m_s1[k];
                m_s1[k]   <= (k == 0) ? bus.KEY1 : bus.KEY3;
            end
            if (ev[0] && !ev[1])                    m_cmd <= P_RIGHT;
            else if (ev[1] && !ev[0])               m_cmd <= P_LEFT;
            else if (!ev[0] && !ev[1] && bus.game_tik) m_cmd <= P_NONE;
        end
    end

    task automatic do_reset;
        reset        = 1'b0;
        bus.KEY1     = 1'b1;
        bus.KEY3     = 1'b1;
        bus.game_tik = 1'b0;
        @(negedge clock_25);
        @(negedge clock_25);
        reset = 1'b1;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock_25);
            vectors++;
            if (bus.right_P !== 1'b0 || bus.left_P !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_hold i=%0d: got r=%b l=%b want r=0 l=0", i, bus.right_P, bus.left_P);
            end
            bus.KEY1 = 1'b0;
            bus.KEY3 = (i % 2 == 0) ? 1'b0 : 1'b1;
        end
        do_reset();
    endtask

    task automatic test_right_hold;
        do_reset();
        bus.KEY1 = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock_25);
            vectors++;
            if (bus.right_P !== (k >= LAT) || bus.left_P !== 1'b0) begin
                miscompares++;
                $display("FAIL right_latency k=%0d: got r=%b l=%b want r=%b l=0", k, bus.right_P, bus.left_P, k >= LAT);
            end
        end
        bus.game_tik = 1'b1;
        #1;
        vectors++;
        if (bus.right_P !== 1'b1) begin
            miscompares++;
            $display("FAIL right_during_tik: got r=%b want r=1", bus.right_P);
        end
        @(negedge clock_25);
        bus.game_tik = 1'b0;
        vectors++;
        if (bus.right_P !== 1'b0 || bus.left_P !== 1'b0) begin
            miscompares++;
            $display("FAIL right_after_tik: got r=%b l=%b want r=0 l=0", bus.right_P, bus.left_P);
        end
        bus.KEY1 = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clock_25);
            vectors++;
            if (bus.right_P !== 1'b0 || bus.left_P !== 1'b0) begin
                miscompares++;
                $display("FAIL right_no_repeat k=%0d: got r=%b l=%b want r=0 l=0", k, bus.right_P, bus.left_P);
            end
        end
    endtask

    task automatic test_glitch;
        do_reset();
        bus.KEY3 = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clock_25);
            vectors++;
            if (bus.right_P !== 1'b0 || bus.left_P !== 1'b0) begin
                miscompares++;
                $display("FAIL glitch k=%0d: got r=%b l=%b want r=0 l=0", k, bus.right_P, bus.left_P);
            end
            if (k == 3) bus.KEY3 = 1'b1;
        end
        bus.KEY3 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock_25);
            vectors++;
            if (bus.left_P !== (k >= LAT) || bus.right_P !== 1'b0) begin
                miscompares++;
                $display("FAIL glitch_recover k=%0d: got r=%b l=%b want r=0 l=%b", k, bus.right_P, bus.left_P, k >= LAT);
            end
        end
    endtask

    task automatic test_override;
        do_reset();
        bus.KEY1 = 1'b0;
        repeat (10) @(negedge clock_25);
        bus.KEY3 = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock_25);
            vectors++;
            if (bus.right_P !== (k < LAT) || bus.left_P !== (k >= LAT)) begin
                miscompares++;
                $display("FAIL override k=%0d: got r=%b l=%b want r=%b l=%b", k, bus.right_P, bus.left_P, k < LAT, k >= LAT);
            end
        end
        bus.game_tik = 1'b1;
        @(negedge clock_25);
        bus.game_tik = 1'b0;
        vectors++;
        if (bus.right_P !== 1'b0 || bus.left_P !== 1'b0) begin
            miscompares++;
            $display("FAIL override_consume: got r=%b l=%b want r=0 l=0", bus.right_P, bus.left_P);
        end
    endtask

    task automatic test_simultaneous;
        do_reset();
        bus.KEY1 = 1'b0;
        bus.KEY3 = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clock_25);
            vectors++;
            if (bus.right_P !== 1'b0 || bus.left_P !== 1'b0) begin
                miscompares++;
                $display("FAIL simultaneous k=%0d: got r=%b l=%b want r=0 l=0", k, bus.right_P, bus.left_P);
            end
        end
    endtask

    task automatic test_event_with_tik;
        logic er;
        logic el;
        do_reset();
        bus.KEY1 = 1'b0;
        repeat (10) @(negedge clock_25);
        bus.KEY3 = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock_25);
            bus.game_tik = 1'b0;
            er = (k < LAT);
            el = (k >= LAT && k < 10);
            vectors++;
            if (bus.right_P !== er || bus.left_P !== el) begin
                miscompares++;
                $display("FAIL event_with_tik k=%0d: got r=%b l=%b want r=%b l=%b", k, bus.right_P, bus.left_P, er, el);
            end
            if (k == LAT - 1 || k == 9) bus.game_tik = 1'b1;
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        bus.KEY1 = 1'b0;
        repeat (8) @(negedge clock_25);
        bus.KEY1 = 1'b1;
        bus.KEY3 = 1'b0;
        repeat (3) @(negedge clock_25);
        #2 reset = 1'b0;
        #1;
        vectors++;
        if (bus.right_P !== 1'b0 || bus.left_P !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_async: got r=%b l=%b want r=0 l=0", bus.right_P, bus.left_P);
        end
        repeat (2) @(negedge clock_25);
        reset = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock_25);
            vectors++;
            if (bus.left_P !== (k >= LAT) || bus.right_P !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_rearm k=%0d: got r=%b l=%b want r=0 l=%b", k, bus.right_P, bus.left_P, k >= LAT);
            end
        end
    endtask

    task automatic test_random;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock_25);
            vectors++;
            if (bus.right_P !== (m_cmd == P_RIGHT) || bus.left_P !== (m_cmd == P_LEFT)) begin
                miscompares++;
                $display("FAIL random i=%0d: got r=%b l=%b want r=%b l=%b", i, bus.right_P, bus.left_P,
                         m_cmd == P_RIGHT, m_cmd == P_LEFT);
            end
            if (!reset) reset = 1'b1;
            else if ($urandom_range(0, 399) == 0) reset = 1'b0;
            if ($urandom_range(0, 5) == 0) bus.KEY1 = ~bus.KEY1;
            if ($urandom_range(0, 5) == 0) bus.KEY3 = ~bus.KEY3;
            bus.game_tik = ($urandom_range(0, 7) == 0);
        end
    endtask

    initial begin
        bus.KEY1     = 1'b1;
        bus.KEY3     = 1'b1;
        bus.game_tik = 1'b0;
        test_reset();
        test_right_hold();
        test_glitch();
        test_override();
        test_simultaneous();
        test_event_with_tik();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
